// File: rtl/can_frame_rx.sv
// CAN 2.0A classic frame receiver: idle qualification, resync, destuffing,
// CRC-15 and form checks. Listen-only; reports a frame or an error code.
module can_frame_rx #(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned SAMPLE_CLK   = 5,
  parameter int unsigned IDLE_BITS    = 11
) (
  input  logic        i_Clock,
  input  logic        i_Rst_n,
  input  logic        i_Rx_Serial,
  output logic        o_Rx_DV,
  output logic [10:0] o_Rx_ID,
  output logic        o_Rx_RTR,
  output logic [3:0]  o_Rx_DLC,
  output logic [63:0] o_Rx_Data,
  output logic        o_Rx_Ack,
  output logic        o_Rx_Err,
  output logic [2:0]  o_Rx_Err_Code
);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(IDLE_BITS + 1);

  typedef enum logic [3:0] {
    S_WAIT_IDLE, S_IDLE, S_SOF_CHECK, S_ARB, S_CTRL, S_DATA,
    S_CRC, S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF
  } state_t;

  state_t         state_q, state_d;
  logic           sync1_q, sync2_q, prev_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]  idle_q, idle_d;
  logic [6:0]     fcnt_q, fcnt_d, nbits_q, nbits_d;
  logic [2:0]     run_q, run_d;
  logic           last_q, last_d;
  logic [10:0]    id_q, id_d;
  logic           rtr_q, rtr_d, ack_q, ack_d;
  logic [3:0]     dlc_q, dlc_d;
  logic [63:0]    data_q, data_d;
  logic [14:0]    crc_q, crc_d, crc_rx_q, crc_rx_d;
  logic           dv_q, dv_d, err_q, err_d, rx_rtr_q, rx_rtr_d, rx_ack_q, rx_ack_d;
  logic [10:0]    rx_id_q, rx_id_d;
  logic [3:0]     rx_dlc_q, rx_dlc_d;
  logic [63:0]    rx_data_q, rx_data_d;
  logic [2:0]     code_q, code_d;

  logic           rx, fall, in_frame, sample, destuff_en, crc_nxt, err_now;
  logic [14:0]    crc_upd;
  logic [3:0]     dlc_new, nbytes;
  logic [2:0]     code_now;
  logic [5:0]     didx;

  assign rx       = sync2_q;
  assign fall     = prev_q & ~sync2_q;
  assign in_frame = state_q inside {S_SOF_CHECK, S_ARB, S_CTRL, S_DATA, S_CRC,
                                    S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF};
  assign sample   = (cnt_q == CW'(SAMPLE_CLK));
  // A run of 5 after the last CRC bit leaves one stuff bit to consume in CRC_DEL
  assign destuff_en = (state_q inside {S_ARB, S_CTRL, S_DATA, S_CRC}) ||
                      (state_q == S_CRC_DEL && run_q == 3'd5);
  assign crc_nxt  = rx ^ crc_q[14];
  assign crc_upd  = {crc_q[13:0], 1'b0} ^ (crc_nxt ? 15'h4599 : 15'h0000);
  assign dlc_new  = {dlc_q[2:0], rx};
  assign nbytes   = (dlc_new > 4'd8) ? 4'd8 : dlc_new;
  assign didx     = 6'd63 - fcnt_q[5:0];

  always_comb begin
    state_d   = state_q;   idle_d   = idle_q;   fcnt_d  = fcnt_q;  nbits_d = nbits_q;
    run_d     = run_q;     last_d   = last_q;   id_d    = id_q;    rtr_d   = rtr_q;
    dlc_d     = dlc_q;     data_d   = data_q;   crc_d   = crc_q;   crc_rx_d = crc_rx_q;
    ack_d     = ack_q;     dv_d     = 1'b0;     err_d   = 1'b0;    code_d  = code_q;
    rx_id_d   = rx_id_q;   rx_rtr_d = rx_rtr_q; rx_dlc_d = rx_dlc_q;
    rx_data_d = rx_data_q; rx_ack_d = rx_ack_q;
    err_now   = 1'b0;      code_now = 3'd0;

    if (state_q == S_IDLE) cnt_d = '0;
    else if (in_frame && fall) cnt_d = '0;
    else if (cnt_q == CW'(CLKS_PER_BIT - 1)) cnt_d = '0;
    else cnt_d = cnt_q + CW'(1);

    if (state_q == S_IDLE && fall) state_d = S_SOF_CHECK;

    if (sample) begin
      if (destuff_en && run_q == 3'd5) begin
        if (rx == last_q) begin
          err_now = 1'b1; code_now = 3'd1;
        end else begin
          run_d = 3'd1; last_d = rx;
        end
      end else begin
        if (destuff_en) begin
          run_d  = (rx == last_q) ? run_q + 3'd1 : 3'd1;
          last_d = rx;
        end
        case (state_q)
          S_WAIT_IDLE: begin
            if (!rx) idle_d = '0;
            else if (idle_q == IW'(IDLE_BITS - 1)) begin
              idle_d = '0; state_d = S_IDLE;
            end else idle_d = IW'(idle_q + IW'(1));
          end
          S_SOF_CHECK: begin
            if (!rx) begin
              state_d = S_ARB; fcnt_d = '0; run_d = 3'd1; last_d = 1'b0;
              crc_d = '0; data_d = '0;
            end else state_d = S_IDLE;
          end
          S_ARB: begin
            crc_d = crc_upd;
            if (fcnt_q == 7'd11) begin
              rtr_d = rx; state_d = S_CTRL; fcnt_d = '0;
            end else begin
              id_d = {id_q[9:0], rx}; fcnt_d = fcnt_q + 7'd1;
            end
          end
          S_CTRL: begin
            crc_d  = crc_upd;
            fcnt_d = fcnt_q + 7'd1;
            if (fcnt_q == 7'd0 && rx) begin
              err_now = 1'b1; code_now = 3'd4;
            end else if (fcnt_q >= 7'd2) begin
              dlc_d = dlc_new;
              if (fcnt_q == 7'd5) begin
                nbits_d = rtr_q ? 7'd0 : {nbytes, 3'b000};
                fcnt_d  = '0;
                state_d = (rtr_q || nbytes == 4'd0) ? S_CRC : S_DATA;
              end
            end
          end
          S_DATA: begin
            crc_d = crc_upd;
            data_d[didx] = rx;
            if (fcnt_q == nbits_q - 7'd1) begin
              state_d = S_CRC; fcnt_d = '0;
            end else fcnt_d = fcnt_q + 7'd1;
          end
          S_CRC: begin
            crc_rx_d = {crc_rx_q[13:0], rx};
            if (fcnt_q == 7'd14) state_d = S_CRC_DEL;
            else fcnt_d = fcnt_q + 7'd1;
          end
          S_CRC_DEL: begin
            if (crc_rx_q != crc_q) begin
              err_now = 1'b1; code_now = 3'd3;
            end else if (!rx) begin
              err_now = 1'b1; code_now = 3'd2;
            end else state_d = S_ACK;
          end
          S_ACK: begin
            ack_d = ~rx; state_d = S_ACK_DEL;
          end
          S_ACK_DEL: begin
            if (!rx) begin
              err_now = 1'b1; code_now = 3'd2;
            end else begin
              state_d = S_EOF; fcnt_d = '0;
            end
          end
          S_EOF: begin
            if (!rx) begin
              err_now = 1'b1; code_now = 3'd2;
            end else if (fcnt_q == 7'd6) begin
              dv_d = 1'b1; state_d = S_IDLE;
              rx_id_d = id_q; rx_rtr_d = rtr_q; rx_dlc_d = dlc_q;
              rx_data_d = data_q; rx_ack_d = ack_q;
            end else fcnt_d = fcnt_q + 7'd1;
          end
          default: ;
        endcase
      end
    end

    if (err_now) begin
      err_d = 1'b1; code_d = code_now; state_d = S_WAIT_IDLE; idle_d = '0;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync1_q <= 1'b1; sync2_q <= 1'b1; prev_q <= 1'b1;
      state_q <= S_WAIT_IDLE; cnt_q <= '0; idle_q <= '0; fcnt_q <= '0; nbits_q <= '0;
      run_q <= '0; last_q <= 1'b1; id_q <= '0; rtr_q <= 1'b0; dlc_q <= '0;
      data_q <= '0; crc_q <= '0; crc_rx_q <= '0; ack_q <= 1'b0;
      dv_q <= 1'b0; err_q <= 1'b0; code_q <= '0; rx_id_q <= '0; rx_rtr_q <= 1'b0;
      rx_dlc_q <= '0; rx_data_q <= '0; rx_ack_q <= 1'b0;
    end else begin
      sync1_q <= i_Rx_Serial; sync2_q <= sync1_q; prev_q <= sync2_q;
      state_q <= state_d; cnt_q <= cnt_d; idle_q <= idle_d; fcnt_q <= fcnt_d; nbits_q <= nbits_d;
      run_q <= run_d; last_q <= last_d; id_q <= id_d; rtr_q <= rtr_d; dlc_q <= dlc_d;
      data_q <= data_d; crc_q <= crc_d; crc_rx_q <= crc_rx_d; ack_q <= ack_d;
      dv_q <= dv_d; err_q <= err_d; code_q <= code_d; rx_id_q <= rx_id_d; rx_rtr_q <= rx_rtr_d;
      rx_dlc_q <= rx_dlc_d; rx_data_q <= rx_data_d; rx_ack_q <= rx_ack_d;
    end
  end

  assign o_Rx_DV       = dv_q;
  assign o_Rx_ID       = rx_id_q;
  assign o_Rx_RTR      = rx_rtr_q;
  assign o_Rx_DLC      = rx_dlc_q;
  assign o_Rx_Data     = rx_data_q;
  assign o_Rx_Ack      = rx_ack_q;
  assign o_Rx_Err      = err_q;
  assign o_Rx_Err_Code = code_q;
endmodule

// File: tb/tb_can_frame_rx.sv
// Directed bench for can_frame_rx: builds stuffed CAN frames with their CRC
// and checks received fields, error codes and reset behaviour.
module tb_can_frame_rx;
  localparam int CPB = 10;

  logic        clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
  logic        dv, rtr, ack, err;
  logic [10:0] id;
  logic [3:0]  dlc;
  logic [63:0] data;
  logic [2:0]  code;

  int n_cmp = 0, n_bad = 0;
  int dv_cnt = 0, err_cnt = 0, both_cnt = 0;
  int d0, e0;
  bit frm[$];

  always #5 clk = ~clk;

  can_frame_rx #(.CLKS_PER_BIT(CPB), .SAMPLE_CLK(5), .IDLE_BITS(11)) dut (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx),
    .o_Rx_DV(dv), .o_Rx_ID(id), .o_Rx_RTR(rtr), .o_Rx_DLC(dlc),
    .o_Rx_Data(data), .o_Rx_Ack(ack), .o_Rx_Err(err), .o_Rx_Err_Code(code)
  );

  always @(negedge clk) begin
    if (dv) dv_cnt++;
    if (err) err_cnt++;
    if (dv && err) both_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Transmitter-side frame construction: raw bits, CRC, stuffing, tail
  task automatic build(input logic [10:0] fid, input logic frtr, input logic fide,
                       input logic [3:0] fdlc, input logic [63:0] fdata,
                       input logic [14:0] crc_flip, input logic skip_stuff,
                       input logic ack_dom, input int eof_dom);
    bit raw[$];
    logic [14:0] c;
    int nb, run;
    bit b, last, skipped, nxt;
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(fid[i]);
    raw.push_back(frtr); raw.push_back(fide); raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(fdlc[i]);
    nb = frtr ? 0 : ((fdlc > 4'd8) ? 8 : int'(fdlc));
    for (int i = 0; i < nb * 8; i++) raw.push_back(fdata[63 - i]);
    c = '0;
    foreach (raw[i]) begin
      nxt = raw[i] ^ c[14];
      c = {c[13:0], 1'b0};
      if (nxt) c = c ^ 15'h4599;
    end
    c = c ^ crc_flip;
    for (int i = 14; i >= 0; i--) raw.push_back(c[i]);
    frm = {};
    run = 0; last = 1'b1; skipped = 1'b0;
    foreach (raw[i]) begin
      b = raw[i];
      frm.push_back(b);
      if (run > 0 && b == last) run++; else run = 1;
      last = b;
      if (run == 5) begin
        if (skip_stuff && !skipped) skipped = 1'b1;
        else begin
          frm.push_back(~b); last = ~b; run = 1;
        end
      end
    end
    frm.push_back(1'b1);
    frm.push_back(ack_dom ? 1'b0 : 1'b1);
    frm.push_back(1'b1);
    for (int k = 1; k <= 7; k++) frm.push_back((k == eof_dom) ? 1'b0 : 1'b1);
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n && i < frm.size(); i++) begin
      rx = frm[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic idle(input int nbits);
    rx = 1'b1;
    repeat (nbits * CPB) @(negedge clk);
  endtask

  task automatic frame_start();
    d0 = dv_cnt; e0 = err_cnt;
  endtask

  task automatic chk_zero_outputs(input string pfx);
    chk({pfx, "_dv"}, 64'(dv), 64'd0);
    chk({pfx, "_id"}, 64'(id), 64'd0);
    chk({pfx, "_rtr"}, 64'(rtr), 64'd0);
    chk({pfx, "_dlc"}, 64'(dlc), 64'd0);
    chk({pfx, "_data"}, data, 64'd0);
    chk({pfx, "_ack"}, 64'(ack), 64'd0);
    chk({pfx, "_err"}, 64'(err), 64'd0);
    chk({pfx, "_code"}, 64'(code), 64'd0);
  endtask

  initial begin
    rx = 1'b1; rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    idle(14);

    // Basic frame ID 0x123, 2 bytes, ACK dominant
    frame_start();
    build(11'h123, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 15'h0, 1'b0, 1'b1, 0);
    send_bits(frm.size()); idle(4);
    chk("a_dv", 64'(dv_cnt - d0), 64'd1);
    chk("a_err", 64'(err_cnt - e0), 64'd0);
    chk("a_id", 64'(id), 64'h123);
    chk("a_rtr", 64'(rtr), 64'd0);
    chk("a_dlc", 64'(dlc), 64'd2);
    chk("a_data", data, 64'hA55A_0000_0000_0000);
    chk("a_ack", 64'(ack), 64'd1);
    idle(10);

    // All-zero frame with heavy stuffing
    frame_start();
    build(11'h000, 1'b0, 1'b0, 4'd8, 64'h0, 15'h0, 1'b0, 1'b1, 0);
    send_bits(frm.size()); idle(4);
    chk("b_dv", 64'(dv_cnt - d0), 64'd1);
    chk("b_err", 64'(err_cnt - e0), 64'd0);
    chk("b_id", 64'(id), 64'h000);
    chk("b_dlc", 64'(dlc), 64'd8);
    chk("b_data", data, 64'h0);
    idle(10);

    // Same frame with the first stuff bit omitted
    frame_start();
    build(11'h000, 1'b0, 1'b0, 4'd8, 64'h0, 15'h0, 1'b1, 1'b1, 0);
    send_bits(frm.size()); idle(4);
    chk("stuff_dv", 64'(dv_cnt - d0), 64'd0);
    chk("stuff_err", 64'(err_cnt - e0), 64'd1);
    chk("stuff_code", 64'(code), 64'd1);
    idle(10);

    // CRC bit flipped; previous frame fields must be retained
    frame_start();
    build(11'h123, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 15'h0010, 1'b0, 1'b1, 0);
    send_bits(frm.size()); idle(4);
    chk("crc_dv", 64'(dv_cnt - d0), 64'd0);
    chk("crc_err", 64'(err_cnt - e0), 64'd1);
    chk("crc_code", 64'(code), 64'd3);
    chk("crc_keep_id", 64'(id), 64'h000);
    chk("crc_keep_dlc", 64'(dlc), 64'd8);
    idle(10);

    // Remote frame, DLC 4, no data, ACK recessive
    frame_start();
    build(11'h2B4, 1'b1, 1'b0, 4'd4, 64'h0, 15'h0, 1'b0, 1'b0, 0);
    send_bits(frm.size()); idle(4);
    chk("rtr_dv", 64'(dv_cnt - d0), 64'd1);
    chk("rtr_id", 64'(id), 64'h2B4);
    chk("rtr_rtr", 64'(rtr), 64'd1);
    chk("rtr_dlc", 64'(dlc), 64'd4);
    chk("rtr_data", data, 64'h0);
    chk("rtr_ack", 64'(ack), 64'd0);
    idle(10);

    // DLC 15 carries 8 bytes
    frame_start();
    build(11'h456, 1'b0, 1'b0, 4'd15, 64'h0102_0304_0506_0708, 15'h0, 1'b0, 1'b1, 0);
    send_bits(frm.size()); idle(4);
    chk("dlc15_dv", 64'(dv_cnt - d0), 64'd1);
    chk("dlc15_dlc", 64'(dlc), 64'd15);
    chk("dlc15_data", data, 64'h0102_0304_0506_0708);
    idle(10);

    // Extended identifier flag
    frame_start();
    build(11'h456, 1'b0, 1'b1, 4'd1, 64'h1100_0000_0000_0000, 15'h0, 1'b0, 1'b1, 0);
    send_bits(frm.size()); idle(4);
    chk("ide_dv", 64'(dv_cnt - d0), 64'd0);
    chk("ide_err", 64'(err_cnt - e0), 64'd1);
    chk("ide_code", 64'(code), 64'd4);
    idle(10);

    // Dominant bit at EOF position 3
    frame_start();
    build(11'h123, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 15'h0, 1'b0, 1'b1, 3);
    send_bits(frm.size()); idle(4);
    chk("eof_dv", 64'(dv_cnt - d0), 64'd0);
    chk("eof_err", 64'(err_cnt - e0), 64'd1);
    chk("eof_code", 64'(code), 64'd2);
    idle(14);

    // Two-clock dominant glitch while idle, then a normal frame
    frame_start();
    rx = 1'b0; repeat (2) @(negedge clk); rx = 1'b1;
    idle(3);
    chk("glitch_dv", 64'(dv_cnt - d0), 64'd0);
    chk("glitch_err", 64'(err_cnt - e0), 64'd0);
    frame_start();
    build(11'h555, 1'b0, 1'b0, 4'd1, 64'h3C00_0000_0000_0000, 15'h0, 1'b0, 1'b1, 0);
    send_bits(frm.size()); idle(4);
    chk("postglitch_dv", 64'(dv_cnt - d0), 64'd1);
    chk("postglitch_id", 64'(id), 64'h555);
    chk("postglitch_data", data, 64'h3C00_0000_0000_0000);
    idle(10);

    // Reset in the data field, then a frame without idle qualification
    build(11'h123, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 15'h0, 1'b0, 1'b1, 0);
    send_bits(26);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("midrst");
    rst_n = 1'b1;
    frame_start();
    send_bits(frm.size()); idle(4);
    chk("noidle_dv", 64'(dv_cnt - d0), 64'd0);
    chk("noidle_id", 64'(id), 64'h000);
    idle(10);
    frame_start();
    send_bits(frm.size()); idle(4);
    chk("qual_dv", 64'(dv_cnt - d0), 64'd1);
    chk("qual_id", 64'(id), 64'h123);
    chk("qual_data", data, 64'hA55A_0000_0000_0000);

    chk("dv_err_overlap", 64'(both_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/can_frame_rx.md
Name: can_frame_rx

Overview:
- Parametrised CAN 2.0A classic frame receiver; successor to the fixed-length serial receiver.
- Adds:
  - bus-idle qualification
  - edge resynchronisation
  - bit destuffing
  - DLC-driven data length
  - CRC-15 check
  - form checking
  - error reporting
- Sits between the CAN transceiver RX pin and the message filter/buffer.
- Listen-only: never drives the bus.

Parameters:
- CLKS_PER_BIT, 10, i_Clock cycles per nominal bit; legal range >= 4.
- SAMPLE_CLK, 5, counter value at which a bit is sampled; 1 <= SAMPLE_CLK <= CLKS_PER_BIT-2.
- IDLE_BITS, 11, consecutive recessive bits required before an SOF is accepted.

Ports:
- i_Clock  in  1  system clock
- i_Rst_n  in  1  asynchronous active-low reset
- i_Rx_Serial  in  1  CAN RX line, 1 = recessive, asynchronous to i_Clock
- o_Rx_DV  out  1  one-cycle pulse, valid frame received
- o_Rx_ID  out  11  identifier, MSB first on bus
- o_Rx_RTR  out  1  RTR bit
- o_Rx_DLC  out  4  raw DLC field
- o_Rx_Data  out  64  data bytes, byte0 at [63:56], unused bytes 0
- o_Rx_Ack  out  1  1 = ACK slot sampled dominant
- o_Rx_Err  out  1  one-cycle pulse, frame aborted
- o_Rx_Err_Code  out  3  1 = stuff, 2 = form, 3 = CRC, 4 = extended ID unsupported; held until next error

Behaviour:
- Reset: asynchronous, active-low.
  - Outputs: all 0.
  - 2-flop input synchroniser: reset to 1.
  - State: WAIT_IDLE.
  - Reset mid-frame discards the frame; no DV, no Err.
- Bit timing:
  - Counter 0..CLKS_PER_BIT-1, wraps.
  - Bit value is sampled when the counter equals SAMPLE_CLK.
  - Every synchronised recessive-to-dominant edge while in a frame forces the counter to 0 (resync).
- WAIT_IDLE:
  - Counts consecutive recessive sampled bits; any dominant bit clears the count.
  - On reaching IDLE_BITS -> IDLE.
- IDLE:
  - Counter held at 0.
  - Synchronised falling edge -> SOF_CHECK (hard sync).
- SOF_CHECK:
  - At the sample point, dominant -> ARB.
  - Otherwise it is a glitch -> IDLE.
  - SOF enters CRC and stuff tracking.
- Destuffing, applied from SOF through the last CRC bit:
  - Track run length of equal sampled bits, stuff bits included.
  - After 5 equal bits, the next bit is a stuff bit. It must differ from the run: if so, discard it and restart the run length at 1; if not, stuff error.
  - A stuff bit may follow the last CRC bit.
  - No destuffing from the CRC delimiter onward.
- Field states (destuffed bits):
  - ARB: 11 ID bits, then RTR.
  - CTRL: IDE, r0, 4 DLC bits. IDE = 1 -> error code 4.
  - DATA: 8 x min(DLC,8) bits; 0 bits if RTR = 1 or DLC = 0.
  - CRC: 15 bits.
  - CRC_DEL: must be recessive, else form error.
  - ACK: record the value; never an error.
  - ACK_DEL: must be recessive, else form error.
  - EOF: 7 recessive bits; any dominant -> form error.
- CRC:
  - CRC-15, polynomial 0x4599, init 0, over destuffed SOF..last data bit.
  - Compared to the received 15-bit field on entry to CRC_DEL; mismatch -> CRC error.
  - The check occurs before the delimiter check.
- Completion:
  - o_Rx_DV pulses the cycle after the 7th EOF bit sample.
  - ID/RTR/DLC/Data/Ack registers update in that same cycle and hold until the next DV.
  - Next state: IDLE. EOF (7 bits) plus 3 intermission bits are satisfied by the CAN protocol itself, so no re-qualification is needed.
- Error:
  - o_Rx_Err pulses the cycle after the offending sample; o_Rx_Err_Code updates in the same cycle.
  - Output data registers are unchanged.
  - Next state: WAIT_IDLE, with the idle count restarted.
- Simultaneous conditions: stuff error has priority over all others at the same sample; CRC error has priority over form error.
- DV and Err never assert in the same cycle.

Test Plan:
- Frame ID=0x123, RTR=0, DLC=2, data 0xA5 0x5A, correct CRC, ACK dominant, after ≥11 idle bits -> o_Rx_DV pulse; o_Rx_ID=0x123, o_Rx_DLC=2, o_Rx_Data=0xA55A000000000000, o_Rx_Ack=1, o_Rx_Err=0.
- ID=0x000, DLC=8, data all 0x00, correct stuffing, valid CRC -> DV; o_Rx_Data=0. Repeat with the 6th equal bit left unstuffed -> o_Rx_Err pulse, code=1, no DV.
- Valid frame with one CRC bit flipped (re-stuffed legally) -> Err, code=3; outputs retain previous frame values.
- RTR=1, DLC=4, no data bytes sent, ACK recessive -> DV; o_Rx_RTR=1, o_Rx_DLC=4, o_Rx_Data=0, o_Rx_Ack=0.
- DLC=15, 8 data bytes sent -> DV with 8 bytes. Separately, IDE=1 -> Err, code=4. Dominant bit in EOF position 3 -> Err, code=2.
- Dominant glitch of 2 clocks in IDLE -> no state advance. i_Rst_n low mid-DATA -> all outputs 0. After release, a frame sent without 11 idle bits is ignored; one preceded by 11 idle bits is received.
